// File: rtl/sound_synth_if.sv
// Event/timebase inputs and audio outputs of the sound generator.
interface sound_synth_if #(
  parameter int NUM_CH  = 2,
  parameter int NUM_EVT = 5
);
  localparam int LVL_W = $clog2(NUM_CH + 1);

  logic               hsync;
  logic               vsync;
  logic [NUM_EVT-1:0] ev;
  logic               audio;
  logic [LVL_W-1:0]   audio_lvl;
  logic [NUM_CH-1:0]  busy;

  modport master (output hsync, vsync, ev, input audio, audio_lvl, busy);
  modport slave  (input hsync, vsync, ev, output audio, audio_lvl, busy);
endinterface

// File: rtl/sound_synth.sv
// Multi-voice event sound generator.
// Game events pick a voice and a tone program from parameter tables; each voice
// is a square wave whose pitch is counted in hsync edges and duration in frames.

// One voice: pitch divider, frame counter and tone program (TONE/SWEEP/PULSE).
module sound_voice #(
  parameter int PER_W = 4,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs_t,
  input  logic             vs_t,
  input  logic             start,
  input  logic [1:0]       st_mode,
  input  logic [PER_W-1:0] st_period,
  input  logic [LEN_W-1:0] st_len,
  output logic             active,
  output logic [1:0]       mode_nxt,
  output logic             sq_nxt
);
  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_SWEEP = 2'd2;
  localparam logic [1:0] M_PULSE = 2'd3;
  localparam int         DIV_W   = PER_W + 4;

  logic [1:0]       mode;
  logic [PER_W-1:0] period, period_nxt;
  logic [LEN_W-1:0] len, len_nxt, frame, frame_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             sq;
  logic             wrap, audible;

  assign active = (mode != M_OFF);

  // Next state: divider first, then a start or a frame step; a start wins over frame updates.
  always_comb begin
    mode_nxt   = mode;
    period_nxt = period;
    len_nxt    = len;
    frame_nxt  = frame;
    div_nxt    = div;
    sq_nxt     = sq;
    wrap       = (div == {period, 4'hF});
    audible    = (mode != M_OFF) && !((mode == M_PULSE) && frame[2]);
    // Divider free-runs even when silent; a start keeps its phase so there is no click.
    // If the period shrank below div, div rolls over at all-ones without toggling.
    if (hs_t) begin
      div_nxt = wrap ? '0 : div + DIV_W'(1);
      if (wrap) sq_nxt = ~sq & audible;
    end
    if (start) begin
      mode_nxt   = st_mode;
      period_nxt = st_period;
      len_nxt    = (st_len == '0) ? LEN_W'(1) : st_len;
      frame_nxt  = '0;
    end else if (vs_t && (mode != M_OFF)) begin
      if (frame == len - LEN_W'(1)) begin
        mode_nxt = M_OFF;
        sq_nxt   = 1'b0;
      end else begin
        frame_nxt = frame + LEN_W'(1);
      end
      // Sweep rises for the first half of the note and falls after, clamped at both ends;
      // it also steps on the final frame, so the parked divider keeps that last period.
      if (mode == M_SWEEP) begin
        if (frame < (len >> 1)) begin
          if (period != '1) period_nxt = period + PER_W'(1);
        end else if (period != '0) begin
          period_nxt = period - PER_W'(1);
        end
      end
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= M_OFF;
      period <= '0;
      len    <= '0;
      frame  <= '0;
      div    <= '0;
      sq     <= 1'b0;
    end else begin
      mode   <= mode_nxt;
      period <= period_nxt;
      len    <= len_nxt;
      frame  <= frame_nxt;
      div    <= div_nxt;
      sq     <= sq_nxt;
    end
  end
endmodule

module sound_synth #(
  parameter int                       NUM_CH     = 2,
  parameter int                       NUM_EVT    = 5,
  parameter int                       PER_W      = 4,
  parameter int                       LEN_W      = 5,
  parameter int                       CH_W       = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [NUM_EVT*PER_W-1:0] EVT_PERIOD = 20'h54339,
  parameter logic [NUM_EVT*LEN_W-1:0] EVT_LEN    = {5'd4, 5'd4, 5'd24, 5'd24, 5'd24},
  parameter logic [NUM_EVT*2-1:0]     EVT_MODE   = 10'b01_01_10_11_11,
  parameter logic [NUM_EVT*CH_W-1:0]  EVT_CH     = 5'b11000,
  parameter logic [NUM_EVT-1:0]       EVT_PRE    = 5'b00111
) (
  input logic          clk,
  input logic          rst_n,
  sound_synth_if.slave bus
);
  localparam int LVL_W = $clog2(NUM_CH + 1);

  logic                         prev_hsync, prev_vsync, hs_t, vs_t;
  logic [NUM_CH-1:0]            start_v, active_v, sq_nxt_v;
  logic [NUM_CH-1:0][1:0]       st_mode_v, mode_nxt_v;
  logic [NUM_CH-1:0][PER_W-1:0] st_per_v;
  logic [NUM_CH-1:0][LEN_W-1:0] st_len_v;
  logic                         hit, hit_pre;
  logic                         audio_q;
  logic [LVL_W-1:0]             lvl_q, lvl_nxt;
  logic [NUM_CH-1:0]            busy_q, busy_nxt;

  // Timebase edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_hsync <= 1'b0;
      prev_vsync <= 1'b0;
    end else begin
      prev_hsync <= bus.hsync;
      prev_vsync <= bus.vsync;
    end
  end

  assign hs_t = bus.hsync & ~prev_hsync;
  assign vs_t = bus.vsync & ~prev_vsync;

  // Dispatch: per voice, the lowest-index enabled event aimed at it is the candidate;
  // scanning downward lets the lowest index overwrite the rest.
  always_comb begin
    start_v   = '0;
    st_mode_v = '0;
    st_per_v  = '0;
    st_len_v  = '0;
    hit       = 1'b0;
    hit_pre   = 1'b0;
    for (int v = 0; v < NUM_CH; v++) begin
      hit     = 1'b0;
      hit_pre = 1'b0;
      for (int e = NUM_EVT - 1; e >= 0; e--) begin
        if (bus.ev[e] && (EVT_CH[e*CH_W +: CH_W] == CH_W'(v)) && (EVT_MODE[e*2 +: 2] != 2'd0)) begin
          hit          = 1'b1;
          hit_pre      = EVT_PRE[e];
          st_mode_v[v] = EVT_MODE[e*2 +: 2];
          st_per_v[v]  = EVT_PERIOD[e*PER_W +: PER_W];
          st_len_v[v]  = EVT_LEN[e*LEN_W +: LEN_W];
        end
      end
      start_v[v] = hit && (hit_pre || !active_v[v]);
    end
  end

  for (genvar v = 0; v < NUM_CH; v++) begin : g_voice
    sound_voice #(.PER_W(PER_W), .LEN_W(LEN_W)) u_voice (
      .clk      (clk),
      .rst_n    (rst_n),
      .hs_t     (hs_t),
      .vs_t     (vs_t),
      .start    (start_v[v]),
      .st_mode  (st_mode_v[v]),
      .st_period(st_per_v[v]),
      .st_len   (st_len_v[v]),
      .active   (active_v[v]),
      .mode_nxt (mode_nxt_v[v]),
      .sq_nxt   (sq_nxt_v[v])
    );
  end

  // Mix: level count and busy flags from the voices' next state.
  always_comb begin
    lvl_nxt  = '0;
    busy_nxt = '0;
    for (int v = 0; v < NUM_CH; v++) begin
      lvl_nxt     = lvl_nxt + LVL_W'(sq_nxt_v[v]);
      busy_nxt[v] = (mode_nxt_v[v] != 2'd0);
    end
  end

  // Output registers, cleared asynchronously so reset silences the pin at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_q <= 1'b0;
      lvl_q   <= '0;
      busy_q  <= '0;
    end else begin
      audio_q <= |sq_nxt_v;
      lvl_q   <= lvl_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.audio     = audio_q;
  assign bus.audio_lvl = lvl_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sound_synth.sv
// Scoreboard bench for sound_synth: a frame/tick-level voice model predicts the
// outputs after every clock edge; a monitor compares them on the falling edge.
module tb_sound_synth;
  localparam int NUM_CH  = 2;
  localparam int NUM_EVT = 5;
  localparam int LVL_W   = $clog2(NUM_CH + 1);
  localparam int FRAME   = 256;

  typedef struct {
    int                tag;
    bit                audio;
    int                lvl;
    bit [NUM_CH-1:0]   busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sound_synth_if #(.NUM_CH(NUM_CH), .NUM_EVT(NUM_EVT)) bus ();
  sound_synth #(.NUM_CH(NUM_CH), .NUM_EVT(NUM_EVT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Event table as read from the parameter defaults.
  int per_t [NUM_EVT] = '{9, 3, 3, 4, 5};
  int len_t [NUM_EVT] = '{24, 24, 24, 4, 4};
  int md_t  [NUM_EVT] = '{3, 3, 2, 1, 1};
  int ch_t  [NUM_EVT] = '{0, 0, 0, 1, 1};
  int pre_t [NUM_EVT] = '{1, 1, 1, 0, 0};

  int m_mode [NUM_CH];
  int m_per  [NUM_CH];
  int m_len  [NUM_CH];
  int m_frm  [NUM_CH];
  int m_div  [NUM_CH];
  bit m_sq   [NUM_CH];
  bit m_ph, m_pv;

  exp_t sb[$];
  exp_t last_x;
  int   ecount = 0;
  int   errs = 0;
  int   checks = 0;
  int   fcnt = 0;
  bit   rnd_tb = 1'b0;
  bit   rst_drv = 1'b0;
  bit   seen2 = 1'b0;

  always @(posedge clk) ecount <= ecount + 1;

  // Reference: state of every voice after one clock edge with the given inputs.
  task automatic model_step(input bit hsi, input bit vsi, input bit [NUM_EVT-1:0] ei, input bit rsti);
    bit hs, vs;
    int cand, f, md0;
    if (!rsti) begin
      m_ph = 0; m_pv = 0;
      for (int v = 0; v < NUM_CH; v++) begin
        m_mode[v] = 0; m_per[v] = 0; m_len[v] = 0; m_frm[v] = 0; m_div[v] = 0; m_sq[v] = 0;
      end
    end else begin
      hs = hsi && !m_ph;
      vs = vsi && !m_pv;
      m_ph = hsi;
      m_pv = vsi;
      for (int v = 0; v < NUM_CH; v++) begin
        cand = -1;
        for (int e = 0; e < NUM_EVT; e++)
          if (cand < 0 && ei[e] && ch_t[e] == v && md_t[e] != 0) cand = e;
        md0 = m_mode[v];
        f   = m_frm[v];
        if (hs) begin
          if (m_div[v] == m_per[v] * 16 + 15) begin
            m_div[v] = 0;
            m_sq[v]  = !m_sq[v] && md0 != 0 && !(md0 == 3 && (f / 4) % 2 == 1);
          end else begin
            m_div[v] = (m_div[v] + 1) % 256;
          end
        end
        if (cand >= 0 && (pre_t[cand] != 0 || md0 == 0)) begin
          m_mode[v] = md_t[cand];
          m_per[v]  = per_t[cand];
          m_len[v]  = (len_t[cand] == 0) ? 1 : len_t[cand];
          m_frm[v]  = 0;
        end else if (vs && md0 != 0) begin
          if (md0 == 2)
            m_per[v] = (f < m_len[v] / 2) ? ((m_per[v] < 15) ? m_per[v] + 1 : 15)
                                          : ((m_per[v] > 0) ? m_per[v] - 1 : 0);
          if (f == m_len[v] - 1) begin
            m_mode[v] = 0;
            m_sq[v]   = 0;
          end else begin
            m_frm[v] = f + 1;
          end
        end
      end
    end
  endtask

  // One clock of stimulus; pushes the outputs expected after the coming edge.
  task automatic cyc(input bit [NUM_EVT-1:0] e);
    exp_t x;
    @(posedge clk); #1;
    rst_n = rst_drv;
    if (rnd_tb) begin
      bus.hsync = ($urandom_range(0, 1) == 1);
      bus.vsync = ($urandom_range(0, 47) == 0);
    end else begin
      bus.hsync = ~bus.hsync;
      fcnt      = (fcnt + 1) % FRAME;
      bus.vsync = (fcnt == 0);
    end
    bus.ev = e;
    model_step(bus.hsync, bus.vsync, e, rst_n);
    x.tag = ecount + 1;
    x.audio = 0; x.lvl = 0; x.busy = '0;
    for (int v = 0; v < NUM_CH; v++) begin
      if (m_sq[v]) begin x.audio = 1; x.lvl++; end
      x.busy[v] = (m_mode[v] != 0);
    end
    sb.push_back(x);
    last_x = x;
  endtask

  task automatic check_now(input string nm, input bit a, input int l, input bit [NUM_CH-1:0] b);
    checks++;
    if (bus.audio !== a || bus.audio_lvl !== LVL_W'(l) || bus.busy !== b) begin
      errs++;
      $display("FAIL %s: got audio=%b lvl=%0d busy=%b, expected audio=%b lvl=%0d busy=%b",
               nm, bus.audio, bus.audio_lvl, bus.busy, a, l, b);
    end
  endtask

  // Monitor: compare the DUT against the entry predicted for the edge just taken.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag < ecount) begin
        x = sb.pop_front();
        checks++; errs++;
        $display("FAIL stale: entry tag=%0d never compared (edge %0d)", x.tag, ecount);
      end
      if (sb.size() > 0 && sb[0].tag == ecount) begin
        x = sb.pop_front();
        checks++;
        if (bus.audio !== x.audio || bus.audio_lvl !== LVL_W'(x.lvl) || bus.busy !== x.busy) begin
          errs++;
          $display("FAIL out edge=%0d: got audio=%b lvl=%0d busy=%b, expected audio=%b lvl=%0d busy=%b",
                   ecount, bus.audio, bus.audio_lvl, bus.busy, x.audio, x.lvl, x.busy);
        end
        if (bus.audio_lvl == LVL_W'(2)) seen2 = 1'b1;
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b1; bus.hsync = 1'b0; bus.vsync = 1'b0; bus.ev = '0;
    #2 rst_n = 1'b0;
    #1 check_now("reset_hold", 0, 0, '0);
    repeat (5) cyc('0);
    rst_drv = 1'b1;
    // idle frames
    repeat (10 * FRAME) cyc('0);
    // voice1 TONE period 5, 4 frames
    cyc(5'b10000);
    repeat (5 * FRAME) cyc('0);
    // non-preempting ev[3] while voice1 busy is dropped
    cyc(5'b10000);
    repeat (FRAME + 37) cyc('0);
    cyc(5'b01000);
    repeat (5 * FRAME) cyc('0);
    // ev[0] beats ev[2] on voice0: PULSE period 9
    cyc(5'b00101);
    repeat (26 * FRAME) cyc('0);
    // SWEEP from period 3
    cyc(5'b00100);
    repeat (26 * FRAME) cyc('0);
    // both voices, then async reset mid-note
    seen2 = 1'b0;
    cyc(5'b00100);
    cyc('0);
    cyc(5'b10000);
    repeat (2 * FRAME) cyc('0);
    checks++;
    if (!seen2) begin
      errs++;
      $display("FAIL lvl2: got max level below 2, expected audio_lvl to reach 2");
    end
    guard = 0;
    while (!last_x.audio && guard < 2000) begin cyc('0); guard++; end
    checks++;
    if (!last_x.audio) begin
      errs++;
      $display("FAIL audio_wait: got no audible cycle within 2000 cycles, expected one");
    end
    @(posedge clk); #2;
    check_now("pre_reset", last_x.audio, last_x.lvl, last_x.busy);
    rst_n = 1'b0;
    #1 check_now("async_reset", 0, 0, '0);
    sb.delete();
    rst_drv = 1'b0;
    model_step(1'b0, 1'b0, '0, 1'b0);
    repeat (4) cyc('0);
    // randomized timebases and events
    rst_drv = 1'b1;
    rnd_tb  = 1'b1;
    repeat (8000) begin
      if ($urandom_range(0, 99) == 0) cyc(NUM_EVT'($urandom));
      else cyc('0);
    end
    @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
